fifo_read_ctrl: RTL

//  Read-side drain controller for the fifo block, clocked in the read_clock domain.
//  - Issues read_enable to the FIFO and captures fifo q one cycle later (FIFO read latency = 1).
//  - Presents words downstream on a valid/ready stream through a small prefetch buffer,
//    so full throughput is sustained with no combinational path from out_ready to read_enable.
//  - Counts delivered reads for status.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_rd_buffer.sv | 55 +++++
 rtl/fifo_read_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared constants for the fifo block.
//   FIFO_RD_LATENCY    : cycles from read strobe to valid q
//   DEFAULT_DATA_WIDTH : default word width
//   DEFAULT_SIZE_BITS  : default log2 of the read-side prefetch buffer depth
package fifo_pkg;

  localparam int FIFO_RD_LATENCY    = 1;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_SIZE_BITS  = 2;

endpackage

// File: rtl/fifo_rd_buffer.sv
// fifo_rd_buffer
//   Circular prefetch buffer for the FIFO read side. Push writes at wr_ptr,
//   pop advances rd_ptr; head_data always shows the entry at rd_ptr.
//   Ports:
//     read_clock  in   clock
//     reset       in   asynchronous, active-high
//     push        in   write push_data into the buffer
//     push_data   in   word to store
//     pop         in   consume head entry (caller guarantees occ != 0)
//     occ         out  number of stored entries, 0..BUF_DEPTH
//     head_data   out  oldest stored word
module fifo_rd_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = 4,
  parameter int BUF_BITS   = DEFAULT_SIZE_BITS
) (
  input  logic                  read_clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [BUF_BITS:0]     occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [BUF_BITS-1:0]   wr_ptr;
  logic [BUF_BITS-1:0]   rd_ptr;

  // Pointers wrap naturally because BUF_DEPTH is a power of two.
  always_ff @(posedge read_clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
//   Read-side drain controller. Issues read_enable to the FIFO, captures q one
//   cycle later into a prefetch buffer and presents it on a valid/ready stream.
//   Reads are issued on credit (buffered + in-flight words < BUF_DEPTH), so
//   out_ready never reaches read_enable combinationally.
//   Ports:
//     read_clock   in   clock
//     reset        in   asynchronous, active-high
//     enable       in   allow new FIFO reads
//     fifo_q       in   FIFO read data, valid the cycle after a read
//     fifo_empty   in   FIFO empty flag
//     read_enable  out  FIFO read strobe
//     out_data     out  head word of the prefetch buffer
//     out_valid    out  out_data is valid
//     out_ready    in   downstream accept
//     words_read   out  words captured from the FIFO since reset (wraps)
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH   = 4,
  parameter int BUF_BITS    = DEFAULT_SIZE_BITS,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   read_clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  fifo_q,
  input  logic                   fifo_empty,
  output logic                   read_enable,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] words_read
);

  localparam logic [BUF_BITS+1:0] DEPTH_CREDIT = (BUF_BITS + 2)'(BUF_DEPTH);

  logic [BUF_BITS:0]          occ;
  logic [FIFO_RD_LATENCY-1:0] inflight;
  logic [BUF_BITS+1:0]        credit_used;
  logic                       push;
  logic                       pop;

  // A single in-flight slot covers the one-cycle FIFO read latency.
  assign push        = inflight[FIFO_RD_LATENCY-1];
  assign credit_used = {1'b0, occ} + {{(BUF_BITS + 1){1'b0}}, inflight[0]};
  assign read_enable = ~reset & enable & ~fifo_empty & (credit_used < DEPTH_CREDIT);
  assign out_valid   = (occ != '0);
  assign pop         = out_valid & out_ready;

  always_ff @(posedge read_clock or posedge reset) begin
    if (reset) begin
      inflight   <= '0;
      words_read <= '0;
    end else begin
      inflight <= FIFO_RD_LATENCY'(read_enable);
      if (push) words_read <= words_read + 1'b1;
    end
  end

  fifo_rd_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .BUF_BITS   (BUF_BITS)
  ) u_buffer (
    .read_clock (read_clock),
    .reset      (reset),
    .push       (push),
    .push_data  (fifo_q),
    .pop        (pop),
    .occ        (occ),
    .head_data  (out_data)
  );

endmodule
